// File: rtl/lines_cleared_tracker.sv
// lines_cleared_tracker: walks the full-row mask of each locked piece top-first,
// hands each full row to the collapse logic over a valid/ack handshake and keeps
// saturating line totals plus a sticky sprint-complete flag.
// Optional build macro: LINES_CLEARED_COMBO_EN adds a consecutive-clearing-lock
// counter on combo_count; without it combo_count is tied to zero.
module lines_cleared_tracker #(
   parameter int ROWS  = 20,
   parameter int GOAL  = 40,
   parameter int ROW_W = 5
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             new_game,
   input  logic             lock_valid,
   input  logic [ROWS-1:0]  full_rows,
   output logic             ready,
   output logic             clear_valid,
   output logic [ROW_W-1:0] clear_row,
   input  logic             clear_ack,
   output logic [5:0]       lines_cleared,
   output logic [2:0]       lines_this_lock,
   output logic             lock_done,
   output logic             sprint_done,
   output logic [4:0]       combo_count
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SCAN   = 2'd1;
   localparam logic [1:0] CLEAR  = 2'd2;
   localparam logic [1:0] FINISH = 2'd3;

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
   localparam logic [6:0]       GOAL_W   = 7'(GOAL);

   // Increments are formed one bit wider, then clamped on carry-out.
   function automatic logic [5:0] sat_inc6(input logic [5:0] v);
      logic [6:0] s;
      s = {1'b0, v} + 7'd1;
      return s[6] ? 6'h3F : s[5:0];
   endfunction

   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      logic [3:0] s;
      s = {1'b0, v} + 4'd1;
      return s[3] ? 3'h7 : s[2:0];
   endfunction

   logic [1:0]       state_q, state_d;
   logic             clear_valid_q, clear_valid_d;
   logic [ROW_W-1:0] clear_row_q, clear_row_d;
   logic [5:0]       lines_q, lines_d;
   logic [2:0]       this_lock_q, this_lock_d;
   logic             lock_done_q, lock_done_d;
   logic             sprint_q, sprint_d;
   logic [ROWS-1:0]  mask_q, mask_d;
   logic [ROW_W-1:0] ptr_q, ptr_d;
   logic [2:0]       cnt_q, cnt_d;

   // Next-state logic: new_game overrides everything, then the lock-walk FSM.
   always_comb begin
      state_d       = state_q;
      clear_valid_d = clear_valid_q;
      clear_row_d   = clear_row_q;
      lines_d       = lines_q;
      this_lock_d   = this_lock_q;
      lock_done_d   = 1'b0;
      sprint_d      = sprint_q | ({1'b0, lines_q} >= GOAL_W);
      mask_d        = mask_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      if (new_game) begin
         state_d       = IDLE;
         clear_valid_d = 1'b0;
         lines_d       = '0;
         this_lock_d   = '0;
         sprint_d      = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (lock_valid) begin
                  mask_d  = full_rows;
                  ptr_d   = '0;
                  cnt_d   = '0;
                  state_d = SCAN;
               end
            end
            SCAN: begin
               // Ascending order: collapsing row r never moves rows below r.
               if (mask_q[ptr_q]) begin
                  clear_row_d = ptr_q;
                  state_d     = CLEAR;
               end else if (ptr_q == LAST_ROW) begin
                  state_d = FINISH;
               end else begin
                  ptr_d = ptr_q + ROW_W'(1);
               end
            end
            CLEAR: begin
               // Request is raised one cycle after entry; ack only counts once it is visible.
               if (!clear_valid_q) begin
                  clear_valid_d = 1'b1;
               end else if (clear_ack) begin
                  clear_valid_d = 1'b0;
                  cnt_d         = sat_inc3(cnt_q);
                  lines_d       = sat_inc6(lines_q);
                  if (ptr_q == LAST_ROW) begin
                     state_d = FINISH;
                  end else begin
                     ptr_d   = ptr_q + ROW_W'(1);
                     state_d = SCAN;
                  end
               end
            end
            FINISH: begin
               lock_done_d = 1'b1;
               this_lock_d = cnt_q;
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Control and visible count registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q       <= IDLE;
         clear_valid_q <= 1'b0;
         clear_row_q   <= '0;
         lines_q       <= '0;
         this_lock_q   <= '0;
         lock_done_q   <= 1'b0;
         sprint_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         clear_valid_q <= clear_valid_d;
         clear_row_q   <= clear_row_d;
         lines_q       <= lines_d;
         this_lock_q   <= this_lock_d;
         lock_done_q   <= lock_done_d;
         sprint_q      <= sprint_d;
      end
   end

   // Per-lock working state; always reloaded when a lock is accepted.
   always_ff @(posedge clk) begin
      mask_q <= mask_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
   end

`ifdef LINES_CLEARED_COMBO_EN
   function automatic logic [4:0] sat_inc5(input logic [4:0] v);
      logic [5:0] s;
      s = {1'b0, v} + 6'd1;
      return s[5] ? 5'h1F : s[4:0];
   endfunction

   logic [4:0] combo_q, combo_d;

   // Combo grows on every lock that cleared something and breaks on an empty lock.
   always_comb begin
      combo_d = combo_q;
      if (new_game) begin
         combo_d = '0;
      end else if (state_q == FINISH) begin
         combo_d = (cnt_q != 3'd0) ? sat_inc5(combo_q) : 5'd0;
      end
   end

   // Combo register, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) combo_q <= '0;
      else        combo_q <= combo_d;
   end

   assign combo_count = combo_q;
`else
   assign combo_count = 5'd0;
`endif

   assign ready           = (state_q == IDLE);
   assign clear_valid     = clear_valid_q;
   assign clear_row       = clear_row_q;
   assign lines_cleared   = lines_q;
   assign lines_this_lock = this_lock_q;
   assign lock_done       = lock_done_q;
   assign sprint_done     = sprint_q;

endmodule

// File: tb/tb_lines_cleared_tracker.sv
// Bench for lines_cleared_tracker: a table of locks plus hand-written sequences
// for goal/saturation, new_game and mid-handshake reset. Expected row indices are
// queued when a lock is driven and popped as the DUT raises each request.
module tb_lines_cleared_tracker;

   localparam int ROWS  = 20;
   localparam int GOAL  = 40;
   localparam int ROW_W = 5;
`ifdef LINES_CLEARED_COMBO_EN
   localparam bit COMBO = 1'b1;
`else
   localparam bit COMBO = 1'b0;
`endif

   logic             clk;
   logic             rst_l;
   logic             new_game;
   logic             lock_valid;
   logic [ROWS-1:0]  full_rows;
   logic             ready;
   logic             clear_valid;
   logic [ROW_W-1:0] clear_row;
   logic             clear_ack;
   logic [5:0]       lines_cleared;
   logic [2:0]       lines_this_lock;
   logic             lock_done;
   logic             sprint_done;
   logic [4:0]       combo_count;

   lines_cleared_tracker #(.ROWS(ROWS), .GOAL(GOAL), .ROW_W(ROW_W)) dut (
      .clk            (clk),
      .rst_l          (rst_l),
      .new_game       (new_game),
      .lock_valid     (lock_valid),
      .full_rows      (full_rows),
      .ready          (ready),
      .clear_valid    (clear_valid),
      .clear_row      (clear_row),
      .clear_ack      (clear_ack),
      .lines_cleared  (lines_cleared),
      .lines_this_lock(lines_this_lock),
      .lock_done      (lock_done),
      .sprint_done    (sprint_done),
      .combo_count    (combo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ROWS-1:0] mask;
      int              dly;
      bit              poke;
      int              exp_n;
      int              exp_total;
      int              exp_combo;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int m_lines = 0;
   bit m_sprint = 1'b0;
   int exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock; the line/sprint model advances across the same edge as the DUT.
   task automatic tick(input logic ack);
      logic pend;
      pend = ack && clear_valid;
      clear_ack = ack;
      if (new_game) begin
         m_lines  = 0;
         m_sprint = 1'b0;
      end else begin
         m_sprint = m_sprint || (m_lines >= GOAL);
         if (pend) m_lines = (m_lines >= 63) ? 63 : m_lines + 1;
      end
      @(negedge clk);
      clear_ack = 1'b0;
      check("lines_cleared", lines_cleared, m_lines);
      check("sprint_done", sprint_done, m_sprint);
   endtask

   task automatic run_lock(input logic [ROWS-1:0] mask, input int dly, input bit poke,
                           output int first_c, output int done_c);
      int  waitc;
      int  row_held;
      int  exp_row;
      bit  prev_v;
      bit  ack_last;
      logic ack;
      for (int r = 0; r < ROWS; r++) if (mask[r]) exp_q.push_back(r);
      first_c  = -1;
      done_c   = -1;
      prev_v   = 1'b0;
      ack_last = 1'b0;
      waitc    = 0;
      row_held = 0;
      check("ready_before_lock", ready, 1);
      full_rows  = mask;
      lock_valid = 1'b1;
      tick(1'b0);
      lock_valid = 1'b0;
      full_rows  = '0;
      for (int c = 0; c < 400; c++) begin
         ack = 1'b0;
         if (ack_last) check("valid_drop_after_ack", clear_valid, 0);
         if (clear_valid) begin
            if (!prev_v) begin
               if (first_c < 0) first_c = c;
               exp_row = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
               check("clear_row", clear_row, exp_row);
               row_held = clear_row;
               waitc = 0;
            end else begin
               check("clear_row_stable", clear_row, row_held);
            end
            ack = (waitc == dly);
            waitc++;
         end
         prev_v   = clear_valid && !ack;
         ack_last = ack;
         if (lock_done) begin
            done_c = c;
            break;
         end
         lock_valid = poke && (c == 5);
         full_rows  = lock_valid ? {ROWS{1'b1}} : '0;
         tick(ack);
         lock_valid = 1'b0;
         full_rows  = '0;
      end
      check("lock_done_seen", int'(done_c >= 0), 1);
      check("rows_outstanding", exp_q.size(), 0);
      exp_q.delete();
      tick(1'b0);
      check("lock_done_pulse", lock_done, 0);
      check("ready_after_lock", ready, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[5];
      int   fc;
      int   dc;
      int   nlock;
      bit   quiet;

      vecs[0] = '{mask: 20'h80000, dly: 2, poke: 1'b0, exp_n: 1, exp_total: 1, exp_combo: 1};
      vecs[1] = '{mask: 20'h00003, dly: 0, poke: 1'b0, exp_n: 2, exp_total: 3, exp_combo: 2};
      vecs[2] = '{mask: 20'h00000, dly: 0, poke: 1'b1, exp_n: 0, exp_total: 3, exp_combo: 0};
      vecs[3] = '{mask: 20'h00400, dly: 1, poke: 1'b0, exp_n: 1, exp_total: 4, exp_combo: 1};
      vecs[4] = '{mask: 20'hF0000, dly: 3, poke: 1'b0, exp_n: 4, exp_total: 8, exp_combo: 2};

      rst_l = 1'b0; new_game = 1'b0; lock_valid = 1'b0; full_rows = '0; clear_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_clear_valid", clear_valid, 0);
      check("rst_clear_row", clear_row, 0);
      check("rst_lines_cleared", lines_cleared, 0);
      check("rst_lines_this_lock", lines_this_lock, 0);
      check("rst_lock_done", lock_done, 0);
      check("rst_sprint_done", sprint_done, 0);
      check("rst_combo", combo_count, 0);
      rst_l = 1'b1;
      tick(1'b0);

      // Stray ack while idle must not count.
      tick(1'b1);
      tick(1'b0);

      for (int i = 0; i < 5; i++) begin
         run_lock(vecs[i].mask, vecs[i].dly, vecs[i].poke, fc, dc);
         check("lines_this_lock", lines_this_lock, vecs[i].exp_n);
         check("lines_total", lines_cleared, vecs[i].exp_total);
         check("combo_count", combo_count, COMBO ? vecs[i].exp_combo : 0);
         if (vecs[i].mask == 20'h80000) check("row19_latency", fc, 21);
         if (vecs[i].mask == 20'h00000) begin
            check("empty_no_request", fc, -1);
            check("empty_done_latency", dc, ROWS + 1);
         end
      end

      // new_game clears all counts.
      new_game = 1'b1;
      tick(1'b0);
      new_game = 1'b0;
      check("ng_ready", ready, 1);
      check("ng_lines_this_lock", lines_this_lock, 0);
      check("ng_combo", combo_count, 0);

      // Ten tetrises reach the goal; tick() tracks the one-cycle sprint lag.
      nlock = 0;
      for (int i = 0; i < 10; i++) begin
         run_lock(20'hF0000, i % 3, 1'b0, fc, dc);
         nlock++;
         check("goal_this_lock", lines_this_lock, 4);
         check("goal_combo", combo_count, COMBO ? nlock : 0);
         if (i == 8) check("sprint_before_goal", sprint_done, 0);
      end
      check("goal_total", lines_cleared, 40);
      check("goal_sprint", sprint_done, 1);

      // Run the total up to saturation.
      for (int i = 0; i < 6; i++) begin
         run_lock(20'hF0000, 0, 1'b0, fc, dc);
         nlock++;
      end
      check("sat_total", lines_cleared, 63);
      check("sat_this_lock4", lines_this_lock, 4);
      run_lock(20'h000FF, 0, 1'b0, fc, dc);
      nlock++;
      check("sat_total_hold", lines_cleared, 63);
      check("sat_this_lock7", lines_this_lock, 7);
      check("sat_combo", combo_count, COMBO ? nlock : 0);
      check("sat_sprint_sticky", sprint_done, 1);

      // new_game coincident with lock_valid discards the lock.
      full_rows  = 20'h00010;
      lock_valid = 1'b1;
      new_game   = 1'b1;
      tick(1'b0);
      lock_valid = 1'b0;
      new_game   = 1'b0;
      full_rows  = '0;
      check("ng_lock_ready", ready, 1);
      check("ng_lock_this_lock", lines_this_lock, 0);
      check("ng_lock_combo", combo_count, 0);
      quiet = 1'b1;
      for (int i = 0; i < ROWS + 5; i++) begin
         tick(1'b0);
         if (clear_valid || lock_done || !ready) quiet = 1'b0;
      end
      check("ng_lock_discarded", quiet, 1);

      // Reset in the middle of a clear handshake.
      run_lock(20'h00002, 0, 1'b0, fc, dc);
      full_rows  = 20'h00004;
      lock_valid = 1'b1;
      tick(1'b0);
      lock_valid = 1'b0;
      full_rows  = '0;
      for (int i = 0; i < 50 && !clear_valid; i++) tick(1'b0);
      check("mid_clear_valid_up", clear_valid, 1);
      check("mid_clear_row", clear_row, 2);
      #2;
      rst_l = 1'b0;
      #1;
      m_lines  = 0;
      m_sprint = 1'b0;
      check("async_rst_clear_valid", clear_valid, 0);
      check("async_rst_ready", ready, 1);
      check("async_rst_lines", lines_cleared, 0);
      @(negedge clk);
      rst_l = 1'b1;
      tick(1'b0);
      check("post_rst_ready", ready, 1);
      check("post_rst_clear_valid", clear_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
